// File: rtl/or1200_mem_arb.sv
// ============================================================================
// Module   : or1200_mem_arb
// Brief    : Instruction/data to single-memory arbiter with access timeout.
//            Define OR1200_MEM_ARB_RR_EN for round-robin tie-break.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module or1200_mem_arb #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    // Instruction port
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic            i_ack,
    output logic            i_err,
    output logic [DW-1:0]   i_rdata,
    // Data port
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_sel,
    output logic            d_ack,
    output logic            d_err,
    output logic [DW-1:0]   d_rdata,
    // Memory port
    output logic            m_req,
    output logic            m_we,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    output logic [DW/8-1:0] m_sel,
    input  logic            m_ack,
    input  logic [DW-1:0]   m_rdata
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] c_TIMEOUT = CW'(TIMEOUT);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_BUSY_I = 2'd1;
    localparam logic [1:0] c_BUSY_D = 2'd2;

    logic [1:0]      r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_m_req;
    logic            r_m_we;
    logic [AW-1:0]   r_m_addr;
    logic [DW-1:0]   r_m_wdata;
    logic [DW/8-1:0] r_m_sel;
    logic            r_i_ack;
    logic            r_i_err;
    logic [DW-1:0]   r_i_rdata;
    logic            r_d_ack;
    logic            r_d_err;
    logic [DW-1:0]   r_d_rdata;

    logic            w_i_valid;
    logic            w_d_valid;
    logic            w_grant_i;
    logic            w_grant_d;
    logic [CW-1:0]   w_cnt_next;
    logic            w_timeout;

    // A requester is still holding req during its own ack cycle, so mask it.
    assign w_i_valid = i_req & ~r_i_ack;
    assign w_d_valid = d_req & ~r_d_ack;

`ifdef OR1200_MEM_ARB_RR_EN
    logic r_last_d;

    assign w_grant_d = w_d_valid & (~w_i_valid | ~r_last_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_d <= 1'b1;
        end else if ((r_state == c_IDLE) && (w_grant_d || w_grant_i)) begin
            r_last_d <= w_grant_d;
        end
    end
`else
    assign w_grant_d = w_d_valid;
`endif

    assign w_grant_i  = w_i_valid & ~w_grant_d;
    assign w_cnt_next = r_cnt + 1'b1;
    assign w_timeout  = (TIMEOUT != 0) && (w_cnt_next == c_TIMEOUT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_m_req   <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_m_sel   <= '0;
            r_i_ack   <= 1'b0;
            r_i_err   <= 1'b0;
            r_i_rdata <= '0;
            r_d_ack   <= 1'b0;
            r_d_err   <= 1'b0;
            r_d_rdata <= '0;
        end else begin
            r_i_ack <= 1'b0;
            r_i_err <= 1'b0;
            r_d_ack <= 1'b0;
            r_d_err <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_grant_d) begin
                        r_state   <= c_BUSY_D;
                        r_cnt     <= '0;
                        r_m_req   <= 1'b1;
                        r_m_we    <= d_we;
                        r_m_addr  <= d_addr;
                        r_m_wdata <= d_wdata;
                        r_m_sel   <= d_sel;
                    end else if (w_grant_i) begin
                        r_state   <= c_BUSY_I;
                        r_cnt     <= '0;
                        r_m_req   <= 1'b1;
                        r_m_we    <= 1'b0;
                        r_m_addr  <= i_addr;
                        r_m_wdata <= '0;
                        r_m_sel   <= '1;
                    end
                end
                c_BUSY_I, c_BUSY_D: begin
                    // m_ack takes precedence over a simultaneous timeout.
                    if (m_ack || w_timeout) begin
                        r_state   <= c_IDLE;
                        r_m_req   <= 1'b0;
                        r_m_we    <= 1'b0;
                        r_m_addr  <= '0;
                        r_m_wdata <= '0;
                        r_m_sel   <= '0;
                        if (r_state == c_BUSY_I) begin
                            r_i_ack   <= 1'b1;
                            r_i_err   <= ~m_ack;
                            r_i_rdata <= m_ack ? m_rdata : '0;
                        end else begin
                            r_d_ack   <= 1'b1;
                            r_d_err   <= ~m_ack;
                            r_d_rdata <= m_ack ? m_rdata : '0;
                        end
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign m_req   = r_m_req;
    assign m_we    = r_m_we;
    assign m_addr  = r_m_addr;
    assign m_wdata = r_m_wdata;
    assign m_sel   = r_m_sel;
    assign i_ack   = r_i_ack;
    assign i_err   = r_i_err;
    assign i_rdata = r_i_rdata;
    assign d_ack   = r_d_ack;
    assign d_err   = r_d_err;
    assign d_rdata = r_d_rdata;

endmodule

`default_nettype wire

// File: tb/tb_or1200_mem_arb.sv
// ============================================================================
// Module   : tb_or1200_mem_arb
// Brief    : Vector table, directed back-to-back sequence and randomized
//            traffic against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_or1200_mem_arb;

    localparam int TO = 4;
`ifdef OR1200_MEM_ARB_RR_EN
    localparam logic [31:0] c_LIR = 32'h11;
    localparam logic [31:0] c_LDR = 32'h22;
`else
    localparam logic [31:0] c_LIR = 32'h22;
    localparam logic [31:0] c_LDR = 32'h11;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we, m_ack;
    logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
    logic [3:0]  d_sel;
    logic        i_ack, i_err, d_ack, d_err, m_req, m_we;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic [3:0]  m_sel;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    or1200_mem_arb #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_sel(d_sel),
        .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_sel(m_sel),
        .m_ack(m_ack), .m_rdata(m_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    // Per-cycle vector: inputs driven this cycle, registered outputs expected this cycle.
    typedef struct {
        logic [31:0] rst, ir, ia, dr, dwe, da, dwd, ds, ma, mrd;
        logic [31:0] emr, emwe, ema, emwd, ems, eia, eie, eda, ede, eir, edr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t V(
        input logic [31:0] rs, ir, ia, dr, dwe, da, dwd, ds, ma, mrd,
        input logic [31:0] emr, emwe, ema, emwd, ems, eia, eie, eda, ede, eir, edr);
        vec_t v;
        v.rst = rs;  v.ir = ir;  v.ia = ia;  v.dr = dr;  v.dwe = dwe; v.da = da;
        v.dwd = dwd; v.ds = ds;  v.ma = ma;  v.mrd = mrd;
        v.emr = emr; v.emwe = emwe; v.ema = ema; v.emwd = emwd; v.ems = ems;
        v.eia = eia; v.eie = eie; v.eda = eda; v.ede = ede; v.eir = eir; v.edr = edr;
        return v;
    endfunction

    task automatic check_outputs(input string tag,
        input logic [31:0] emr, emwe, ema, emwd, ems, eia, eie, eda, ede, eir, edr);
        chk({tag, ".m_req"},   32'(m_req),   emr);
        chk({tag, ".m_we"},    32'(m_we),    emwe);
        chk({tag, ".m_addr"},  m_addr,       ema);
        chk({tag, ".m_wdata"}, m_wdata,      emwd);
        chk({tag, ".m_sel"},   32'(m_sel),   ems);
        chk({tag, ".i_ack"},   32'(i_ack),   eia);
        chk({tag, ".i_err"},   32'(i_err),   eie);
        chk({tag, ".d_ack"},   32'(d_ack),   eda);
        chk({tag, ".d_err"},   32'(d_err),   ede);
        chk({tag, ".i_rdata"}, i_rdata,      eir);
        chk({tag, ".d_rdata"}, d_rdata,      edr);
    endtask

    // ---------------- reference model (transaction level) ----------------
    int          mb;         // 0 idle, 1 fetch in flight, 2 data in flight
    int          elapsed;
    logic        last_d;
    logic        mc_we;
    logic [31:0] mc_addr, mc_wdata;
    logic [3:0]  mc_sel;
    logic        e_ia, e_ie, e_da, e_de;
    logic [31:0] e_ir, e_dr;

    task automatic model_step();
        logic n_ia, n_ie, n_da, n_de, iv, dv, gd, gi;
        n_ia = 1'b0; n_ie = 1'b0; n_da = 1'b0; n_de = 1'b0;
        if (rst) begin
            mb = 0; elapsed = 0; last_d = 1'b1;
            mc_we = 1'b0; mc_addr = '0; mc_wdata = '0; mc_sel = '0;
            e_ir = '0; e_dr = '0;
        end else if (mb != 0) begin
            elapsed++;
            if (m_ack || (TO != 0 && elapsed == TO)) begin
                if (mb == 1) begin
                    n_ia = 1'b1; n_ie = !m_ack; e_ir = m_ack ? m_rdata : '0;
                end else begin
                    n_da = 1'b1; n_de = !m_ack; e_dr = m_ack ? m_rdata : '0;
                end
                mb = 0;
                mc_we = 1'b0; mc_addr = '0; mc_wdata = '0; mc_sel = '0;
            end
        end else begin
            iv = i_req && !e_ia;
            dv = d_req && !e_da;
`ifdef OR1200_MEM_ARB_RR_EN
            gd = dv && (!iv || !last_d);
`else
            gd = dv;
`endif
            gi = iv && !gd;
            if (gd) begin
                mb = 2; mc_we = d_we; mc_addr = d_addr; mc_wdata = d_wdata; mc_sel = d_sel;
            end else if (gi) begin
                mb = 1; mc_we = 1'b0; mc_addr = i_addr; mc_wdata = '0; mc_sel = 4'hF;
            end
            if (gd || gi) begin
                last_d = gd; elapsed = 0;
            end
        end
        e_ia = n_ia; e_ie = n_ie; e_da = n_da; e_de = n_de;
    endtask

    initial begin
        int n_acks, gap, low_cnt;
        logic prev_mreq, started;
        logic [31:0] addrs[2];

        rst = 1'b1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
        d_wdata = 0; d_sel = 0; m_ack = 0; m_rdata = 0;
        repeat (3) @(posedge clk);

        // Single fetch, 2 BUSY cycles
        tbl.push_back(V(0,1,'h100,0,0,0,0,0,0,0,                0,0,0,0,0,        0,0,0,0,0,0));
        tbl.push_back(V(0,1,'h100,0,0,0,0,0,0,0,                1,0,'h100,0,'hF,  0,0,0,0,0,0));
        tbl.push_back(V(0,1,'h100,0,0,0,0,0,1,'hA8200005,       1,0,'h100,0,'hF,  0,0,0,0,0,0));
        tbl.push_back(V(0,1,'h100,0,0,0,0,0,0,0,                0,0,0,0,0,        1,0,0,0,'hA8200005,0));
        tbl.push_back(V(0,0,0,0,0,0,0,0,0,0,                    0,0,0,0,0,        0,0,0,0,'hA8200005,0));
        // Simultaneous requests, immediate m_ack
        tbl.push_back(V(1,0,0,0,0,0,0,0,0,0,                    0,0,0,0,0,        0,0,0,0,'hA8200005,0));
        tbl.push_back(V(0,1,'h100,1,1,'h2000,5,'hF,0,0,         0,0,0,0,0,        0,0,0,0,0,0));
`ifdef OR1200_MEM_ARB_RR_EN
        tbl.push_back(V(0,1,'h100,1,1,'h2000,5,'hF,1,'h11,      1,0,'h100,0,'hF,  0,0,0,0,0,0));
        tbl.push_back(V(0,1,'h100,1,1,'h2000,5,'hF,0,0,         0,0,0,0,0,        1,0,0,0,'h11,0));
        tbl.push_back(V(0,0,0,1,1,'h2000,5,'hF,1,'h22,          1,1,'h2000,5,'hF, 0,0,0,0,'h11,0));
        tbl.push_back(V(0,0,0,1,1,'h2000,5,'hF,0,0,             0,0,0,0,0,        0,0,1,0,'h11,'h22));
`else
        tbl.push_back(V(0,1,'h100,1,1,'h2000,5,'hF,1,'h11,      1,1,'h2000,5,'hF, 0,0,0,0,0,0));
        tbl.push_back(V(0,1,'h100,1,1,'h2000,5,'hF,0,0,         0,0,0,0,0,        0,0,1,0,0,'h11));
        tbl.push_back(V(0,1,'h100,0,0,0,0,0,1,'h22,             1,0,'h100,0,'hF,  0,0,0,0,0,'h11));
        tbl.push_back(V(0,1,'h100,0,0,0,0,0,0,0,                0,0,0,0,0,        1,0,0,0,'h22,'h11));
`endif
        tbl.push_back(V(0,0,0,0,0,0,0,0,0,0,                    0,0,0,0,0,        0,0,0,0,c_LIR,c_LDR));
        // Timeout, then m_ack on the very cycle the limit is reached, then idle m_ack
        tbl.push_back(V(1,0,0,0,0,0,0,0,0,0,                    0,0,0,0,0,        0,0,0,0,c_LIR,c_LDR));
        tbl.push_back(V(0,0,0,1,0,'h40,0,'hF,0,0,               0,0,0,0,0,        0,0,0,0,0,0));
        for (int k = 0; k < 4; k++)
            tbl.push_back(V(0,0,0,1,0,'h40,0,'hF,0,0,           1,0,'h40,0,'hF,   0,0,0,0,0,0));
        tbl.push_back(V(0,0,0,1,0,'h40,0,'hF,0,0,               0,0,0,0,0,        0,0,1,1,0,0));
        tbl.push_back(V(0,0,0,1,0,'h44,0,'hF,0,0,               0,0,0,0,0,        0,0,0,0,0,0));
        for (int k = 0; k < 3; k++)
            tbl.push_back(V(0,0,0,1,0,'h44,0,'hF,0,0,           1,0,'h44,0,'hF,   0,0,0,0,0,0));
        tbl.push_back(V(0,0,0,1,0,'h44,0,'hF,1,'h77,            1,0,'h44,0,'hF,   0,0,0,0,0,0));
        tbl.push_back(V(0,0,0,1,0,'h44,0,'hF,0,0,               0,0,0,0,0,        0,0,1,0,0,'h77));
        tbl.push_back(V(0,0,0,0,0,0,0,0,1,'h99,                 0,0,0,0,0,        0,0,0,0,0,'h77));
        tbl.push_back(V(0,0,0,0,0,0,0,0,0,0,                    0,0,0,0,0,        0,0,0,0,0,'h77));
        // Reset in the middle of a data access, late m_ack
        tbl.push_back(V(0,0,0,1,1,'h80,'hAB,'h3,0,0,            0,0,0,0,0,        0,0,0,0,0,'h77));
        tbl.push_back(V(0,0,0,1,1,'h80,'hAB,'h3,0,0,            1,1,'h80,'hAB,'h3, 0,0,0,0,0,'h77));
        tbl.push_back(V(1,0,0,1,1,'h80,'hAB,'h3,0,0,            1,1,'h80,'hAB,'h3, 0,0,0,0,0,'h77));
        tbl.push_back(V(0,0,0,0,0,0,0,0,1,'h55,                 0,0,0,0,0,        0,0,0,0,0,0));
        tbl.push_back(V(0,0,0,0,0,0,0,0,0,0,                    0,0,0,0,0,        0,0,0,0,0,0));

        foreach (tbl[n]) begin
            @(negedge clk);
            rst = tbl[n].rst[0]; i_req = tbl[n].ir[0]; i_addr = tbl[n].ia;
            d_req = tbl[n].dr[0]; d_we = tbl[n].dwe[0]; d_addr = tbl[n].da;
            d_wdata = tbl[n].dwd; d_sel = tbl[n].ds[3:0]; m_ack = tbl[n].ma[0];
            m_rdata = tbl[n].mrd;
            check_outputs($sformatf("tbl%0d", n), tbl[n].emr, tbl[n].emwe, tbl[n].ema,
                tbl[n].emwd, tbl[n].ems, tbl[n].eia, tbl[n].eie, tbl[n].eda,
                tbl[n].ede, tbl[n].eir, tbl[n].edr);
        end

        // Back-to-back fetches with req held high
        @(negedge clk);
        rst = 1'b0; i_req = 1'b1; i_addr = 32'h100; d_req = 1'b0; m_ack = 1'b0;
        n_acks = 0; gap = -1; low_cnt = 0; prev_mreq = 1'b0; started = 1'b0;
        addrs[0] = '0; addrs[1] = '0;
        for (int c = 0; c < 40 && n_acks < 2; c++) begin
            @(negedge clk);
            if (m_req && !prev_mreq) begin
                if (started) gap = low_cnt;
                else addrs[0] = m_addr;
                if (started) addrs[1] = m_addr;
                started = 1'b1;
            end
            if (!m_req && started) low_cnt++;
            prev_mreq = m_req;
            m_ack = m_req;
            m_rdata = 32'hC0DE_0000 + 32'(c);
            if (i_ack) begin
                n_acks++;
                low_cnt = 0;
                if (n_acks == 1) i_addr = 32'h104;
                else i_req = 1'b0;
            end
        end
        chk("b2b.acks", 32'(n_acks), 32'd2);
        chk("b2b.addr0", addrs[0], 32'h100);
        chk("b2b.addr1", addrs[1], 32'h104);
        chk("b2b.gap_ge1", 32'(gap >= 1), 32'd1);
        m_ack = 1'b0;

        // Randomized traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (c > 0)
                check_outputs($sformatf("rnd%0d", c), 32'(mb != 0), 32'(mc_we), mc_addr,
                    mc_wdata, 32'(mc_sel), 32'(e_ia), 32'(e_ie), 32'(e_da), 32'(e_de),
                    e_ir, e_dr);
            rst = (c == 0) || ($urandom_range(0, 199) == 0);
            if (!(i_req && !e_ia) || c == 0) begin
                i_req  = $urandom_range(0, 1) == 1;
                i_addr = $urandom() & 32'hFFFF_FFFC;
            end
            if (!(d_req && !e_da) || c == 0) begin
                d_req   = $urandom_range(0, 1) == 1;
                d_we    = $urandom_range(0, 1) == 1;
                d_addr  = $urandom() & 32'hFFFF_FFFC;
                d_wdata = $urandom();
                d_sel   = 4'($urandom_range(0, 15));
            end
            m_ack   = $urandom_range(0, 2) == 0;
            m_rdata = $urandom();
            model_step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
